// File: rtl/dm_sba_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_sba_pkg
// Description : Shared definitions for the debug-module System Bus Access
//               block: DMI register addresses, sbcs field positions,
//               sberror codes and the access FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_sba_pkg;

    // DMI register addresses decoded by the SBA block
    localparam logic [6:0] c_SBCS       = 7'h38;
    localparam logic [6:0] c_SBADDRESS0 = 7'h39;
    localparam logic [6:0] c_SBDATA0    = 7'h3C;

    // sbcs field positions
    localparam int unsigned c_SBCS_VERSION_LSB  = 29;
    localparam int unsigned c_SBCS_BUSYERROR    = 22;
    localparam int unsigned c_SBCS_BUSY         = 21;
    localparam int unsigned c_SBCS_READONADDR   = 20;
    localparam int unsigned c_SBCS_ACCESS_LSB   = 17;
    localparam int unsigned c_SBCS_AUTOINC      = 16;
    localparam int unsigned c_SBCS_READONDATA   = 15;
    localparam int unsigned c_SBCS_ERROR_LSB    = 12;
    localparam int unsigned c_SBCS_ASIZE_LSB    = 5;
    localparam int unsigned c_SBCS_ACCESS32     = 2;

    // sberror codes
    localparam logic [2:0] c_ERR_NONE    = 3'd0;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] c_ERR_BADADDR = 3'd2;
    localparam logic [2:0] c_ERR_ALIGN   = 3'd3;
    localparam logic [2:0] c_ERR_SIZE    = 3'd4;

    // only 32-bit accesses are supported
    localparam logic [2:0] c_ACCESS_32   = 3'd2;

    // bus access FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

endpackage : dm_sba_pkg
`default_nettype wire

// File: rtl/sb_access_master.sv
`default_nettype none
// ============================================================================
// Module      : sb_access_master
// Description : Debug-module System Bus Access initiator. Holds sbcs,
//               sbaddress0 and sbdata0, turns DMI accesses to them into
//               single-word bus reads/writes and reports errors in sbcs.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               dmi_addr/wdata     - DMI register address / write data
//               dmi_write/read     - one-cycle DMI strobes
//               dmi_rdata          - registered DMI read data
//               sb_addr/sb_wdata   - bus byte address / write data
//               sb_read/sb_write   - one-cycle bus request pulses
//               sb_ready/sb_rdata  - responder completion / read data
// Revision    : 1.0 - initial release
// ============================================================================
module sb_access_master
    import dm_sba_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  dmi_addr,
    input  logic [31:0] dmi_wdata,
    input  logic        dmi_write,
    input  logic        dmi_read,
    output logic [31:0] dmi_rdata,
    output logic [31:0] sb_addr,
    output logic [31:0] sb_wdata,
    input  logic [31:0] sb_rdata,
    output logic        sb_read,
    output logic        sb_write,
    input  logic        sb_ready
);

    localparam int unsigned c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    // architectural registers
    logic [31:0]        r_sbaddress0;
    logic [31:0]        r_sbdata0;
    logic               r_readonaddr;
    logic               r_readondata;
    logic               r_autoinc;
    logic [2:0]         r_sbaccess;
    logic [2:0]         r_sberror;
    logic               r_busyerror;

    // FSM and bus-side registers
    logic [1:0]         r_state;
    logic               r_is_write;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_dmi_rdata;
    logic [31:0]        r_sb_addr;
    logic [31:0]        r_sb_wdata;
    logic               r_sb_read;
    logic               r_sb_write;

    logic               w_busy;
    logic               w_sticky;
    logic               w_wr;
    logic               w_rd;
    logic               w_sel_cs;
    logic               w_sel_addr;
    logic               w_sel_data;
    logic               w_busy_hit;
    logic               w_trig_read;
    logic               w_trig_write;
    logic [31:0]        w_trig_addr;
    logic [31:0]        w_trig_wdata;
    logic [2:0]         w_chk_err;
    logic [31:0]        w_sbcs;
    logic [31:0]        w_rd_val;

    assign w_busy     = (r_state != c_ST_IDLE);
    assign w_sticky   = (r_sberror != c_ERR_NONE) || r_busyerror;
    assign w_wr       = dmi_write;
    assign w_rd       = dmi_read && !dmi_write;  // write wins a collision
    assign w_sel_cs   = (dmi_addr == c_SBCS);
    assign w_sel_addr = (dmi_addr == c_SBADDRESS0);
    assign w_sel_data = (dmi_addr == c_SBDATA0);

    // Touching the address/data registers mid-transaction is a busy error
    assign w_busy_hit = w_busy && ((w_wr && (w_sel_addr || w_sel_data)) ||
                                   (w_rd && w_sel_data));

    assign w_trig_read  = !w_busy && !w_sticky &&
                          ((w_wr && w_sel_addr && r_readonaddr) ||
                           (w_rd && w_sel_data && r_readondata));
    assign w_trig_write = !w_busy && !w_sticky && w_wr && w_sel_data;

    // A trigger uses the value being written in the same cycle
    assign w_trig_addr  = (w_wr && w_sel_addr) ? dmi_wdata : r_sbaddress0;
    assign w_trig_wdata = (w_wr && w_sel_data) ? dmi_wdata : r_sbdata0;

    // Pre-checks, first match wins; 33-bit sum so addresses near the top of
    // the 32-bit space cannot wrap into range.
    always_comb begin
        w_chk_err = c_ERR_NONE;
        if (r_sbaccess != c_ACCESS_32) begin
            w_chk_err = c_ERR_SIZE;
        end else if (w_trig_addr[1:0] != 2'b00) begin
            w_chk_err = c_ERR_ALIGN;
        end else if (({1'b0, w_trig_addr} + 33'd3) >= 33'(MEM_BYTES)) begin
            w_chk_err = c_ERR_BADADDR;
        end
    end

    always_comb begin
        w_sbcs = '0;
        w_sbcs[c_SBCS_VERSION_LSB +: 3] = 3'd1;
        w_sbcs[c_SBCS_BUSYERROR]        = r_busyerror;
        w_sbcs[c_SBCS_BUSY]             = w_busy;
        w_sbcs[c_SBCS_READONADDR]       = r_readonaddr;
        w_sbcs[c_SBCS_ACCESS_LSB +: 3]  = r_sbaccess;
        w_sbcs[c_SBCS_AUTOINC]          = r_autoinc;
        w_sbcs[c_SBCS_READONDATA]       = r_readondata;
        w_sbcs[c_SBCS_ERROR_LSB +: 3]   = r_sberror;
        w_sbcs[c_SBCS_ASIZE_LSB +: 7]   = 7'd32;
        w_sbcs[c_SBCS_ACCESS32]         = 1'b1;
    end

    always_comb begin
        w_rd_val = '0;
        if (w_sel_cs) begin
            w_rd_val = w_sbcs;
        end else if (w_sel_addr) begin
            w_rd_val = r_sbaddress0;
        end else if (w_sel_data) begin
            w_rd_val = r_sbdata0;  // old value even when it starts a read
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sbaddress0 <= '0;
            r_sbdata0    <= '0;
            r_readonaddr <= 1'b0;
            r_readondata <= 1'b0;
            r_autoinc    <= 1'b0;
            r_sbaccess   <= c_ACCESS_32;
            r_sberror    <= c_ERR_NONE;
            r_busyerror  <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_is_write   <= 1'b0;
            r_cnt        <= '0;
            r_dmi_rdata  <= '0;
            r_sb_addr    <= '0;
            r_sb_wdata   <= '0;
            r_sb_read    <= 1'b0;
            r_sb_write   <= 1'b0;
        end else begin
            // DMI register writes; FSM updates below take precedence
            if (w_wr) begin
                if (w_sel_cs) begin
                    r_busyerror  <= r_busyerror & ~dmi_wdata[c_SBCS_BUSYERROR];
                    r_sberror    <= r_sberror & ~dmi_wdata[c_SBCS_ERROR_LSB +: 3];
                    r_readonaddr <= dmi_wdata[c_SBCS_READONADDR];
                    r_sbaccess   <= dmi_wdata[c_SBCS_ACCESS_LSB +: 3];
                    r_autoinc    <= dmi_wdata[c_SBCS_AUTOINC];
                    r_readondata <= dmi_wdata[c_SBCS_READONDATA];
                end
                if (w_sel_addr && !w_busy) begin
                    r_sbaddress0 <= dmi_wdata;
                end
                if (w_sel_data && !w_busy) begin
                    r_sbdata0 <= dmi_wdata;
                end
            end

            if (w_busy_hit) begin
                r_busyerror <= 1'b1;
            end

            if (w_wr) begin
                r_dmi_rdata <= '0;
            end else if (w_rd) begin
                r_dmi_rdata <= w_rd_val;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_trig_read || w_trig_write) begin
                        if (w_chk_err != c_ERR_NONE) begin
                            r_sberror <= w_chk_err;
                        end else begin
                            r_sb_addr  <= w_trig_addr;
                            r_sb_wdata <= w_trig_wdata;
                            r_is_write <= w_trig_write;
                            r_sb_read  <= !w_trig_write;
                            r_sb_write <= w_trig_write;
                            r_state    <= c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    // request is a single-cycle pulse
                    r_sb_read  <= 1'b0;
                    r_sb_write <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (sb_ready) begin
                        if (!r_is_write) begin
                            r_sbdata0 <= sb_rdata;
                        end
                        if (r_autoinc) begin
                            r_sbaddress0 <= r_sbaddress0 + 32'd4;
                        end
                        r_state <= c_ST_IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_sberror <= c_ERR_TIMEOUT;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign dmi_rdata = r_dmi_rdata;
    assign sb_addr   = r_sb_addr;
    assign sb_wdata  = r_sb_wdata;
    assign sb_read   = r_sb_read;
    assign sb_write  = r_sb_write;

endmodule : sb_access_master
`default_nettype wire

// File: tb/tb_sb_access_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_access_master
// Description : Self-checking bench for sb_access_master: directed vector
//               table, hand-written error/timeout/reset sequences and a
//               randomized phase checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_access_master;

    localparam int MEM_BYTES = 128;
    localparam int TIMEOUT   = 16;

    localparam logic [6:0]  c_CS   = 7'h38;
    localparam logic [6:0]  c_ADR  = 7'h39;
    localparam logic [6:0]  c_DAT  = 7'h3C;
    localparam logic [31:0] c_BASE = 32'h2004_0404;  // sbcs after reset

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  dmi_addr = '0;
    logic [31:0] dmi_wdata = '0;
    logic        dmi_write = 1'b0;
    logic        dmi_read = 1'b0;
    logic [31:0] dmi_rdata;
    logic [31:0] sb_addr;
    logic [31:0] sb_wdata;
    logic [31:0] sb_rdata;
    logic        sb_read;
    logic        sb_write;
    logic        sb_ready;

    sb_access_master #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_write (dmi_write),
        .dmi_read  (dmi_read),
        .dmi_rdata (dmi_rdata),
        .sb_addr   (sb_addr),
        .sb_wdata  (sb_wdata),
        .sb_rdata  (sb_rdata),
        .sb_read   (sb_read),
        .sb_write  (sb_write),
        .sb_ready  (sb_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- byte-addressed memory responder ----------------
    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        resp_en   = 1'b1;
    logic        r_rdy     = 1'b0;
    logic        inj_rdy   = 1'b0;
    logic [31:0] r_rdata   = '0;
    logic [31:0] inj_rdata = '0;
    logic        prev_rd   = 1'b0;
    logic        prev_wr   = 1'b0;
    int          n_rd_pulse = 0;
    int          n_wr_pulse = 0;
    int          n_width_err = 0;
    logic [31:0] last_addr = '0;
    int          resp_a;

    assign sb_ready = r_rdy | inj_rdy;
    assign sb_rdata = inj_rdy ? inj_rdata : r_rdata;

    always @(posedge clk) begin
        if (rst) begin
            r_rdy   <= 1'b0;
            prev_rd <= 1'b0;
            prev_wr <= 1'b0;
        end else begin
            r_rdy   <= 1'b0;
            prev_rd <= sb_read;
            prev_wr <= sb_write;
            if ((sb_read && prev_rd) || (sb_write && prev_wr))
                n_width_err <= n_width_err + 1;
            if (sb_read || sb_write) begin
                last_addr <= sb_addr;
                if (sb_read)  n_rd_pulse <= n_rd_pulse + 1;
                if (sb_write) n_wr_pulse <= n_wr_pulse + 1;
                if (resp_en) begin
                    r_rdy <= 1'b1;
                    if (sb_addr <= 32'(MEM_BYTES - 4)) begin
                        resp_a = int'(sb_addr);
                        if (sb_write) begin
                            for (int b = 0; b < 4; b++)
                                mem[resp_a + b] <= sb_wdata[8*b +: 8];
                        end else begin
                            r_rdata <= {mem[resp_a+3], mem[resp_a+2],
                                        mem[resp_a+1], mem[resp_a]};
                        end
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic dmi_op(input logic wr, input logic rd, input logic [6:0] a,
                          input logic [31:0] d, output logic [31:0] q);
        @(negedge clk);
        dmi_addr  = a;
        dmi_wdata = d;
        dmi_write = wr;
        dmi_read  = rd;
        @(negedge clk);
        dmi_write = 1'b0;
        dmi_read  = 1'b0;
        q = dmi_rdata;
    endtask

    task automatic dwr(input logic [6:0] a, input logic [31:0] d);
        logic [31:0] q;
        dmi_op(1'b1, 1'b0, a, d, q);
    endtask

    task automatic drd(input logic [6:0] a, output logic [31:0] q);
        dmi_op(1'b0, 1'b1, a, 32'h0, q);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] m_addr, m_data;
    logic        m_roa, m_rod, m_ai, m_berr;
    logic [2:0]  m_acc, m_err;
    int          m_bus_ops;

    function automatic logic [31:0] m_sbcs();
        return {3'b001, 6'b0, m_berr, 1'b0, m_roa, m_acc, m_ai, m_rod,
                m_err, 7'd32, 2'b0, 1'b1, 2'b0};
    endfunction

    task automatic m_access(input bit is_write);
        if (m_err != 0 || m_berr) return;
        if (m_acc != 3'd2)                             m_err = 3'd4;
        else if (m_addr % 4 != 0)                      m_err = 3'd3;
        else if (longint'(m_addr) + 3 >= MEM_BYTES)    m_err = 3'd2;
        else begin
            m_bus_ops++;
            for (int b = 0; b < 4; b++) begin
                if (is_write) ref_mem[int'(m_addr) + b] = m_data[8*b +: 8];
                else          m_data[8*b +: 8] = ref_mem[int'(m_addr) + b];
            end
            if (m_ai) m_addr = m_addr + 32'd4;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [6:0]  a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic wr, input logic rd,
                                input logic [6:0] a, input logic [31:0] d,
                                input logic chk, input logic [31:0] exp,
                                input string name);
        vec_t v;
        v.wr = wr; v.rd = rd; v.a = a; v.d = d;
        v.chk = chk; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        int          rd0, wr0, diff;

        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);

        tbl[0]  = mk(0, 1, c_CS,  32'h0,          1, c_BASE,        "reset_sbcs");
        tbl[1]  = mk(0, 1, c_ADR, 32'h0,          1, 32'h0,         "reset_sbaddress0");
        tbl[2]  = mk(0, 1, c_DAT, 32'h0,          1, 32'h0,         "reset_sbdata0");
        tbl[3]  = mk(0, 1, 7'h10, 32'h0,          1, 32'h0,         "other_addr_read");
        tbl[4]  = mk(1, 0, c_ADR, 32'h10,         0, 32'h0,         "set_addr");
        tbl[5]  = mk(1, 0, c_DAT, 32'hDEADBEEF,   0, 32'h0,         "write_data");
        tbl[6]  = mk(1, 0, c_CS,  32'h0014_0000,  0, 32'h0,         "set_readonaddr");
        tbl[7]  = mk(1, 1, c_CS,  32'h0014_0000,  1, 32'h0,         "rd_wr_collision");
        tbl[8]  = mk(1, 0, c_ADR, 32'h10,         0, 32'h0,         "readonaddr_trig");
        tbl[9]  = mk(0, 1, c_DAT, 32'h0,          1, 32'hDEADBEEF,  "readback_data");
        tbl[10] = mk(0, 1, c_CS,  32'h0,          1, 32'h2014_0404, "sbcs_readonaddr");
        tbl[11] = mk(0, 1, c_ADR, 32'h0,          1, 32'h10,        "addr_no_autoinc");

        do_reset();
        check("reset_sb_read",  {31'b0, sb_read},  32'h0);
        check("reset_sb_write", {31'b0, sb_write}, 32'h0);
        check("reset_sb_addr",  sb_addr,           32'h0);

        for (int i = 0; i < 12; i++) begin
            dmi_op(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, q);
            if (tbl[i].chk) check(tbl[i].name, q, tbl[i].exp);
            idle(4);
        end
        check("mem_0x10", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
        check("write_pulses", 32'(n_wr_pulse), 32'd1);
        check("read_pulses",  32'(n_rd_pulse), 32'd1);
        check("last_bus_addr", last_addr, 32'h10);

        // ---- autoincrement + readondata ----
        do_reset();
        {mem[3], mem[2], mem[1], mem[0]} = 32'h1111_1111;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h2222_2222;
        dwr(c_CS, 32'h0005_8000);
        dwr(c_ADR, 32'h0);
        drd(c_DAT, q); idle(4);
        check("rod_first_old", q, 32'h0);
        drd(c_DAT, q); idle(4);
        check("rod_second", q, 32'h1111_1111);
        drd(c_ADR, q);
        check("autoinc_addr", q, 32'h8);
        drd(c_DAT, q);
        check("rod_third_data", q, 32'h2222_2222);

        // ---- pre-check errors ----
        do_reset();
        rd0 = n_rd_pulse; wr0 = n_wr_pulse;
        dwr(c_ADR, 32'h2); dwr(c_DAT, 32'h1); idle(3);
        drd(c_CS, q);
        check("err_align", q, 32'h2004_3404);
        dwr(c_CS, 32'h0000_7000);
        drd(c_CS, q);
        check("err_clear_w1c", q, 32'h2000_0404);
        dwr(c_ADR, 32'h80); dwr(c_DAT, 32'h1); idle(3);
        drd(c_CS, q);
        check("err_size", q, 32'h2000_4404);
        dwr(c_CS, 32'h0004_7000);
        dwr(c_DAT, 32'h2); idle(3);
        drd(c_CS, q);
        check("err_badaddr", q, 32'h2004_2404);
        check("err_no_bus", 32'((n_rd_pulse - rd0) + (n_wr_pulse - wr0)), 32'd0);
        dwr(c_CS, 32'h0004_7000);
        dwr(c_ADR, 32'h7C); dwr(c_DAT, 32'h55AA_55AA); idle(4);
        drd(c_CS, q);
        check("last_word_ok", q, c_BASE);
        check("last_word_mem", {24'h0, mem[MEM_BYTES-1]}, 32'h55);
        check("last_word_pulse", 32'(n_wr_pulse - wr0), 32'd1);

        // ---- timeout and busy error ----
        resp_en = 1'b0;
        wr0 = n_wr_pulse;
        dwr(c_DAT, 32'hA5A5_A5A5); idle(6);
        drd(c_CS, q);
        check("busy_in_wait", q, 32'h2024_0404);
        dwr(c_DAT, 32'h1234_5678);
        idle(20);
        drd(c_CS, q);
        check("timeout_sbcs", q, 32'h2044_1404);
        drd(c_DAT, q);
        check("busy_write_dropped", q, 32'hA5A5_A5A5);
        resp_en = 1'b1;
        dwr(c_DAT, 32'h0BAD_F00D); idle(4);
        check("sticky_no_trigger", 32'(n_wr_pulse - wr0), 32'd1);
        drd(c_DAT, q);
        check("sticky_reg_update", q, 32'h0BAD_F00D);
        dwr(c_CS, 32'h0044_7000);
        drd(c_CS, q);
        check("sticky_cleared", q, c_BASE);

        // ---- reset in WAIT ----
        resp_en = 1'b0;
        dwr(c_DAT, 32'hCAFE_F00D); idle(3);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rstwait_dmi_rdata", dmi_rdata, 32'h0);
        check("rstwait_sb_addr",   sb_addr,   32'h0);
        check("rstwait_sb_wdata",  sb_wdata,  32'h0);
        check("rstwait_strobes",   {30'b0, sb_read, sb_write}, 32'h0);
        inj_rdata = 32'hFFFF_0000;
        @(negedge clk); inj_rdy = 1'b1;
        @(negedge clk); inj_rdy = 1'b0;
        resp_en = 1'b1;
        drd(c_DAT, q);
        check("rstwait_late_ready", q, 32'h0);
        drd(c_CS, q);
        check("rstwait_sbcs", q, c_BASE);

        // ---- randomized phase against the model ----
        do_reset();
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = mem[i];
        m_addr = 0; m_data = 0; m_roa = 0; m_rod = 0; m_ai = 0;
        m_acc = 3'd2; m_err = 0; m_berr = 0; m_bus_ops = 0;
        rd0 = n_rd_pulse; wr0 = n_wr_pulse;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] d;
            int          kind;
            kind = $urandom_range(0, 5);
            d    = $urandom;
            case (kind)
                0: begin
                    d[19:17] = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
                    dwr(c_CS, d);
                    m_berr = m_berr & ~d[22];
                    m_err  = m_err & ~d[14:12];
                    m_roa  = d[20]; m_acc = d[19:17];
                    m_ai   = d[16]; m_rod = d[15];
                end
                1: begin
                    if ($urandom_range(0, 5) != 0) d = 32'($urandom_range(0, 31)) * 4;
                    dwr(c_ADR, d);
                    m_addr = d;
                    if (m_roa) m_access(0);
                end
                2: begin
                    dwr(c_DAT, d);
                    m_data = d;
                    m_access(1);
                end
                3: begin
                    drd(c_CS, q);
                    check("rand_sbcs", q, m_sbcs());
                end
                4: begin
                    drd(c_ADR, q);
                    check("rand_sbaddress0", q, m_addr);
                end
                default: begin
                    drd(c_DAT, q);
                    check("rand_sbdata0", q, m_data);
                    if (m_rod) m_access(0);
                end
            endcase
            idle(4);
        end
        check("rand_bus_ops", 32'((n_rd_pulse - rd0) + (n_wr_pulse - wr0)),
              32'(m_bus_ops));
        diff = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("rand_mem_bytes_diff", 32'(diff), 32'd0);
        check("pulse_width", 32'(n_width_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sb_access_master
`default_nettype wire
